// File: rtl/dp_arbiter_pkg.sv
// Shared types for the data-pointer port arbiter: segment selector,
// per-requester command bundle and arbiter FSM states.
package dp_arbiter_pkg;

   typedef enum logic [2:0] {
      DS0 = 3'd0,
      DS1 = 3'd1,
      ES  = 3'd2,
      SS  = 3'd3,
      CS  = 3'd4
   } sreg_index_e;

   typedef struct packed {
      logic [15:0] addr;
      logic [15:0] dout;
      sreg_index_e sreg;
      logic        write;
      logic        wide;
      logic        io;
      logic        zero_seg;
   } dp_cmd_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } arb_state_e;

   localparam dp_cmd_t DP_CMD_RESET = '{
      addr:     16'h0000,
      dout:     16'h0000,
      sreg:     DS0,
      write:    1'b0,
      wide:     1'b0,
      io:       1'b0,
      zero_seg: 1'b0
   };

endpackage

// File: rtl/dp_arbiter_rr_pick.sv
// Combinational round-robin picker: first pending requester found when
// scanning upward from last+1, wrapping around to last itself.
module dp_arbiter_rr_pick #(
   parameter int NUM_REQ = 3,
   parameter int IW      = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] pending,
   input  logic [IW-1:0]      last,
   output logic               valid,
   output logic [IW-1:0]      index
);

   int          cand;
   logic [IW-1:0] cidx;

   // Scan NUM_REQ candidates in rotation order; the earliest hit wins
   always_comb begin
      valid = 1'b0;
      index = '0;
      cand  = 0;
      cidx  = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = int'(last) + k;
         if (cand >= NUM_REQ) begin
            cand = cand - NUM_REQ;
         end else begin
            cand = cand;
         end
         cidx = cand[IW-1:0];
         if (!valid && pending[cidx]) begin
            valid = 1'b1;
            index = cidx;
         end else begin
            valid = valid;
            index = index;
         end
      end
   end

endmodule

// File: rtl/dp_arbiter.sv
// Shares the bus control unit's data-pointer port between several toggle-handshake
// requesters, round-robin with an optional bus lock held by the last grantee.
module dp_arbiter
   import dp_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 3
) (
   input  logic                      clk,
   input  logic                      n_reset,
   input  logic                      ce_1,
   input  logic                      ce_2,
   input  logic [NUM_REQ-1:0]        rq_req,
   output logic [NUM_REQ-1:0]        rq_ack,
   input  dp_cmd_t [NUM_REQ-1:0]     rq_cmd,
   input  logic [NUM_REQ-1:0]        rq_lock,
   output logic [15:0]               rq_din,
   output logic [15:0]               dp_addr,
   output logic [15:0]               dp_dout,
   output sreg_index_e               dp_sreg,
   output logic                      dp_write,
   output logic                      dp_wide,
   output logic                      dp_io,
   output logic                      dp_zero_seg,
   output logic                      dp_req,
   input  logic                      dp_ready,
   input  logic [15:0]               dp_din,
   output logic                      buslock_prefix,
   output logic [$clog2(NUM_REQ)-1:0] owner,
   output logic                      busy
);

   localparam int IW = $clog2(NUM_REQ);

   arb_state_e          state;
   arb_state_e          next_state;
   dp_cmd_t             cur;
   logic                en;
   logic                wait_skip;
   logic                locked_valid;
   logic [IW-1:0]       locked_owner;
   logic [IW-1:0]       last_grant;
   logic [NUM_REQ-1:0]  pending;
   logic [NUM_REQ-1:0]  eligible;
   logic [NUM_REQ-1:0]  lock_mask;
   logic                lock_hold;
   logic                pick_valid;
   logic [IW-1:0]       pick_index;
   logic                do_pick;
   logic                do_issue;
   logic                do_skip_clr;
   logic                do_done;
   logic                do_unlock;

   assign en      = ce_1 | ce_2;
   assign pending = rq_req ^ rq_ack;

   assign dp_addr     = cur.addr;
   assign dp_dout     = cur.dout;
   assign dp_sreg     = cur.sreg;
   assign dp_write    = cur.write;
   assign dp_wide     = cur.wide;
   assign dp_io       = cur.io;
   assign dp_zero_seg = cur.zero_seg;

   assign buslock_prefix = locked_valid | (busy & rq_lock[owner]);

   // A held lock restricts eligibility to the locked owner only
   always_comb begin
      lock_mask               = '0;
      lock_mask[locked_owner] = 1'b1;
      lock_hold               = locked_valid & rq_lock[locked_owner];
      if (lock_hold) begin
         eligible = pending & lock_mask;
      end else begin
         eligible = pending;
      end
   end

   dp_arbiter_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IW      (IW)
   ) u_rr_pick (
      .pending (eligible),
      .last    (last_grant),
      .valid   (pick_valid),
      .index   (pick_index)
   );

   // Next-state and action strobes; nothing happens without a clock enable
   always_comb begin
      next_state  = state;
      do_pick     = 1'b0;
      do_issue    = 1'b0;
      do_skip_clr = 1'b0;
      do_done     = 1'b0;
      do_unlock   = 1'b0;
      if (en) begin
         case (state)
            ST_IDLE: begin
               do_unlock = locked_valid & ~rq_lock[locked_owner];
               if (pick_valid) begin
                  do_pick    = 1'b1;
                  next_state = ST_ISSUE;
               end else begin
                  next_state = ST_IDLE;
               end
            end
            ST_ISSUE: begin
               do_issue   = 1'b1;
               next_state = ST_WAIT;
            end
            ST_WAIT: begin
               // dp_ready still shows the pre-toggle idle level on the first cycle
               if (wait_skip) begin
                  do_skip_clr = 1'b1;
                  next_state  = ST_WAIT;
               end else if (dp_ready) begin
                  do_done    = 1'b1;
                  next_state = ST_IDLE;
               end else begin
                  next_state = ST_WAIT;
               end
            end
            default: begin
               next_state = ST_IDLE;
            end
         endcase
      end else begin
         next_state = state;
      end
   end

   // FSM state register
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Transfer registers, handshake toggles and lock bookkeeping
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         cur          <= DP_CMD_RESET;
         dp_req       <= 1'b0;
         rq_ack       <= '0;
         rq_din       <= 16'hffff;
         owner        <= '0;
         busy         <= 1'b0;
         last_grant   <= IW'(NUM_REQ - 1);
         locked_valid <= 1'b0;
         locked_owner <= '0;
         wait_skip    <= 1'b0;
      end else begin
         if (do_pick) begin
            cur   <= rq_cmd[pick_index];
            owner <= pick_index;
            busy  <= 1'b1;
         end
         if (do_issue) begin
            dp_req    <= ~dp_req;
            wait_skip <= 1'b1;
         end
         if (do_skip_clr) begin
            wait_skip <= 1'b0;
         end
         if (do_done) begin
            if (!cur.write) begin
               rq_din <= dp_din;
            end
            rq_ack[owner] <= ~rq_ack[owner];
            last_grant    <= owner;
            locked_owner  <= owner;
            locked_valid  <= rq_lock[owner];
            busy          <= 1'b0;
         end
         if (do_unlock) begin
            locked_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_dp_arbiter.sv
// Directed self-checking bench for dp_arbiter with a small bus control unit model
// that answers each dp_req toggle after a programmable number of cycles.
module tb_dp_arbiter;
   import dp_arbiter_pkg::*;

   localparam int NUM_REQ = 3;

   logic                 clk = 1'b0;
   logic                 n_reset;
   logic                 ce_1;
   logic                 ce_2;
   logic [NUM_REQ-1:0]   rq_req;
   logic [NUM_REQ-1:0]   rq_ack;
   dp_cmd_t [NUM_REQ-1:0] rq_cmd;
   logic [NUM_REQ-1:0]   rq_lock;
   logic [15:0]          rq_din;
   logic [15:0]          dp_addr;
   logic [15:0]          dp_dout;
   sreg_index_e          dp_sreg;
   logic                 dp_write;
   logic                 dp_wide;
   logic                 dp_io;
   logic                 dp_zero_seg;
   logic                 dp_req;
   logic                 dp_ready;
   logic [15:0]          dp_din;
   logic                 buslock_prefix;
   logic [1:0]           owner;
   logic                 busy;

   int n_checks = 0;
   int n_errors = 0;

   logic        bcu_ack;
   logic        bcu_ready;
   int          bcu_cnt;
   int          bcu_delay;
   logic [15:0] bcu_rdata;

   logic        prev_req;
   int          log_n;
   logic [15:0] log_addr [16];
   logic        watch_lock;
   logic        lock_gap;
   logic        lock_seen;
   int          cyc;

   assign dp_ready = bcu_ready;
   assign dp_din   = bcu_rdata;

   always #5 clk = ~clk;

   dp_arbiter #(.NUM_REQ(NUM_REQ)) dut (
      .clk            (clk),
      .n_reset        (n_reset),
      .ce_1           (ce_1),
      .ce_2           (ce_2),
      .rq_req         (rq_req),
      .rq_ack         (rq_ack),
      .rq_cmd         (rq_cmd),
      .rq_lock        (rq_lock),
      .rq_din         (rq_din),
      .dp_addr        (dp_addr),
      .dp_dout        (dp_dout),
      .dp_sreg        (dp_sreg),
      .dp_write       (dp_write),
      .dp_wide        (dp_wide),
      .dp_io          (dp_io),
      .dp_zero_seg    (dp_zero_seg),
      .dp_req         (dp_req),
      .dp_ready       (dp_ready),
      .dp_din         (dp_din),
      .buslock_prefix (buslock_prefix),
      .owner          (owner),
      .busy           (busy)
   );

   // Bus control unit: ready drops one clock after a toggle, returns after bcu_delay
   always @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         bcu_ack   <= 1'b0;
         bcu_ready <= 1'b1;
         bcu_cnt   <= 0;
      end else if (bcu_ready && (dp_req != bcu_ack)) begin
         bcu_ready <= 1'b0;
         bcu_cnt   <= bcu_delay;
      end else if (!bcu_ready) begin
         if (bcu_cnt <= 1) begin
            bcu_ready <= 1'b1;
            bcu_ack   <= dp_req;
         end else begin
            bcu_cnt <= bcu_cnt - 1;
         end
      end
   end

   // Log the address of every issued transfer
   always @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         prev_req <= 1'b0;
         log_n    <= 0;
      end else if (dp_req != prev_req) begin
         prev_req <= dp_req;
         if (log_n < 16) log_addr[log_n[3:0]] <= dp_addr;
         log_n <= log_n + 1;
      end
   end

   // Watch buslock_prefix for gaps inside a locked window and for any assertion
   always @(negedge clk or negedge n_reset) begin
      if (!n_reset) begin
         lock_gap  <= 1'b0;
         lock_seen <= 1'b0;
      end else begin
         if (watch_lock && !buslock_prefix) lock_gap <= 1'b1;
         if (buslock_prefix) lock_seen <= 1'b1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic dp_cmd_t mk_cmd(input logic [15:0] a, input logic [15:0] d,
                                      input sreg_index_e s, input logic w,
                                      input logic wd, input logic io);
      dp_cmd_t c;
      c.addr     = a;
      c.dout     = d;
      c.sreg     = s;
      c.write    = w;
      c.wide     = wd;
      c.io       = io;
      c.zero_seg = 1'b0;
      return c;
   endfunction

   task automatic do_reset();
      n_reset = 1'b0;
      rq_req  = '0;
      rq_lock = '0;
      ce_1    = 1'b1;
      ce_2    = 1'b0;
      repeat (2) @(negedge clk);
      n_reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic wait_ack(input int i, output int cycles);
      int c = 0;
      while ((rq_ack[i] !== rq_req[i]) && (c < 300)) begin
         @(negedge clk);
         c++;
      end
      cycles = c;
      check($sformatf("ack%0d", i), 32'(rq_ack[i]), 32'(rq_req[i]));
   endtask

   task automatic wait_busy();
      int c = 0;
      while ((busy !== 1'b1) && (c < 50)) begin
         @(negedge clk);
         c++;
      end
      check("busy_seen", 32'(busy), 32'h1);
   endtask

   task automatic wait_bcu_low();
      int c = 0;
      while ((bcu_ready !== 1'b0) && (c < 50)) begin
         @(negedge clk);
         c++;
      end
      check("bcu_started", 32'(bcu_ready), 32'h0);
   endtask

   initial begin
      n_reset    = 1'b0;
      ce_1       = 1'b1;
      ce_2       = 1'b0;
      rq_req     = '0;
      rq_lock    = '0;
      rq_cmd     = '0;
      bcu_delay  = 2;
      bcu_rdata  = 16'hBEEF;
      watch_lock = 1'b0;
      do_reset();

      // reset values
      check("rst_dp_req", 32'(dp_req), 32'h0);
      check("rst_ack", 32'(rq_ack), 32'h0);
      check("rst_din", 32'(rq_din), 32'hffff);
      check("rst_sreg", 32'(dp_sreg), 32'(DS0));
      check("rst_addr", 32'(dp_addr), 32'h0);
      check("rst_owner", 32'(owner), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_lock", 32'(buslock_prefix), 32'h0);

      // single read
      rq_cmd[0] = mk_cmd(16'h0010, 16'h0000, DS1, 1'b0, 1'b1, 1'b0);
      rq_req[0] = ~rq_req[0];
      wait_ack(0, cyc);
      check("single_latency", 32'(cyc), 32'd6);
      check("single_din", 32'(rq_din), 32'hBEEF);
      check("single_toggles", 32'(log_n), 32'd1);
      check("single_addr", 32'(log_addr[0]), 32'h0010);
      check("single_sreg", 32'(dp_sreg), 32'(DS1));
      check("single_wide", 32'(dp_wide), 32'h1);
      check("single_nolock", 32'(lock_seen), 32'h0);

      // no clock enable: nothing moves
      do_reset();
      ce_1      = 1'b0;
      bcu_rdata = 16'h5A5A;
      rq_cmd[0] = mk_cmd(16'h0020, 16'h0000, DS0, 1'b0, 1'b0, 1'b0);
      rq_req[0] = ~rq_req[0];
      repeat (5) @(negedge clk);
      check("noce_busy", 32'(busy), 32'h0);
      check("noce_dp_req", 32'(dp_req), 32'h0);
      check("noce_ack", 32'(rq_ack), 32'h0);
      check("noce_addr", 32'(dp_addr), 32'h0);
      ce_2 = 1'b1;
      wait_ack(0, cyc);
      check("noce_din", 32'(rq_din), 32'h5A5A);

      // simultaneous requests after reset
      do_reset();
      rq_cmd[0] = mk_cmd(16'h0100, 16'h0000, DS0, 1'b0, 1'b1, 1'b0);
      rq_cmd[1] = mk_cmd(16'h0200, 16'h0000, DS0, 1'b0, 1'b1, 1'b0);
      rq_cmd[2] = mk_cmd(16'h0300, 16'h0000, DS0, 1'b0, 1'b1, 1'b0);
      rq_req    = 3'b111;
      wait_ack(2, cyc);
      check("simul_all_acks", 32'(rq_ack), 32'h7);
      check("simul_toggles", 32'(log_n), 32'd3);
      check("simul_order0", 32'(log_addr[0]), 32'h0100);
      check("simul_order1", 32'(log_addr[1]), 32'h0200);
      check("simul_order2", 32'(log_addr[2]), 32'h0300);

      // fairness: req0 keeps re-requesting while req1 waits
      do_reset();
      rq_cmd[0] = mk_cmd(16'h0A00, 16'h0000, DS0, 1'b0, 1'b0, 1'b0);
      rq_cmd[1] = mk_cmd(16'h0B00, 16'h0000, DS0, 1'b0, 1'b0, 1'b0);
      rq_req    = 3'b011;
      wait_ack(0, cyc);
      rq_req[0] = ~rq_req[0];
      wait_ack(1, cyc);
      rq_req[1] = ~rq_req[1];
      wait_ack(0, cyc);
      wait_ack(1, cyc);
      check("fair_toggles", 32'(log_n), 32'd4);
      check("fair_g0", 32'(log_addr[0]), 32'h0A00);
      check("fair_g1", 32'(log_addr[1]), 32'h0B00);
      check("fair_g2", 32'(log_addr[2]), 32'h0A00);
      check("fair_g3", 32'(log_addr[3]), 32'h0B00);

      // locked sequence by req1 holds off pending req0
      do_reset();
      bcu_rdata  = 16'hC0DE;
      rq_cmd[1]  = mk_cmd(16'h1111, 16'hAAAA, ES, 1'b1, 1'b1, 1'b0);
      rq_lock[1] = 1'b1;
      rq_req[1]  = ~rq_req[1];
      wait_busy();
      watch_lock = 1'b1;
      rq_cmd[0]  = mk_cmd(16'h0500, 16'h0000, DS0, 1'b0, 1'b1, 1'b0);
      rq_req[0]  = ~rq_req[0];
      wait_ack(1, cyc);
      rq_cmd[1]  = mk_cmd(16'h1112, 16'hBBBB, ES, 1'b1, 1'b1, 1'b0);
      rq_req[1]  = ~rq_req[1];
      wait_ack(1, cyc);
      check("lock_req0_held", 32'(rq_ack[0]), 32'h0);
      check("lock_write_din", 32'(rq_din), 32'hffff);
      watch_lock = 1'b0;
      check("lock_no_gap", 32'(lock_gap), 32'h0);
      rq_lock[1] = 1'b0;
      wait_ack(0, cyc);
      check("lock_toggles", 32'(log_n), 32'd3);
      check("lock_g0", 32'(log_addr[0]), 32'h1111);
      check("lock_g1", 32'(log_addr[1]), 32'h1112);
      check("lock_g2", 32'(log_addr[2]), 32'h0500);
      check("lock_read_din", 32'(rq_din), 32'hC0DE);
      check("lock_released", 32'(buslock_prefix), 32'h0);

      // slow bus control unit: fields stay put while waiting
      do_reset();
      bcu_delay = 10;
      rq_cmd[0] = mk_cmd(16'h2222, 16'h3333, SS, 1'b1, 1'b1, 1'b1);
      rq_req[0] = ~rq_req[0];
      wait_bcu_low();
      for (int k = 0; k < 9; k++) begin
         check("hold_addr", 32'(dp_addr), 32'h2222);
         check("hold_dout", 32'(dp_dout), 32'h3333);
         check("hold_ack", 32'(rq_ack[0]), 32'h0);
         @(negedge clk);
      end
      wait_ack(0, cyc);
      check("hold_io", 32'(dp_io), 32'h1);
      check("hold_write_din", 32'(rq_din), 32'hffff);

      // reset in the middle of a wait
      do_reset();
      bcu_delay = 5;
      bcu_rdata = 16'h7777;
      rq_cmd[0] = mk_cmd(16'h4444, 16'h0000, DS1, 1'b0, 1'b1, 1'b0);
      rq_req[0] = ~rq_req[0];
      wait_bcu_low();
      n_reset = 1'b0;
      rq_req  = '0;
      #1;
      check("mid_rst_dp_req", 32'(dp_req), 32'h0);
      check("mid_rst_ack", 32'(rq_ack), 32'h0);
      check("mid_rst_busy", 32'(busy), 32'h0);
      check("mid_rst_owner", 32'(owner), 32'h0);
      check("mid_rst_addr", 32'(dp_addr), 32'h0);
      check("mid_rst_din", 32'(rq_din), 32'hffff);
      check("mid_rst_lock", 32'(buslock_prefix), 32'h0);
      repeat (2) @(negedge clk);
      n_reset = 1'b1;
      @(negedge clk);
      bcu_delay = 2;
      bcu_rdata = 16'h1234;
      rq_req[0] = ~rq_req[0];
      wait_ack(0, cyc);
      check("post_rst_latency", 32'(cyc), 32'd6);
      check("post_rst_din", 32'(rq_din), 32'h1234);
      check("post_rst_toggles", 32'(log_n), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
